// File: rtl/maxpool2x2.sv
// 2x2 stride-2 signed max pooling over a row-major pixel stream.
// A line buffer holds the even-row pair maxima until the matching odd-row pair arrives.
module maxpool2x2 #(
    parameter int DATA_W = 24,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic signed [DATA_W-1:0] in,
    output logic                     valid_out,
    output logic signed [DATA_W-1:0] out,
    output logic                     frame_done
);

    localparam int HALF_W = IMG_W / 2;
    localparam int CW     = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

    logic [CW-1:0]            col_r;
    logic [RW-1:0]            row_r;
    logic signed [DATA_W-1:0] hold_r;
    logic signed [DATA_W-1:0] line_buf_r [HALF_W];
    logic                     valid_out_r;
    logic signed [DATA_W-1:0] out_r;
    logic                     frame_done_r;

    logic [AW-1:0]            buf_idx_s;
    logic                     last_col_s;
    logic                     last_row_s;
    logic signed [DATA_W-1:0] pair_max_s;
    logic signed [DATA_W-1:0] window_max_s;

    // Window position decode and pair/window maxima for the current pixel
    always_comb begin
        buf_idx_s    = AW'(col_r >> 1);
        last_col_s   = (col_r == CW'(IMG_W - 1));
        last_row_s   = (row_r == RW'(IMG_H - 1));
        pair_max_s   = smax(hold_r, in);
        window_max_s = smax(line_buf_r[buf_idx_s], pair_max_s);
    end

    // Position counters and registered pooled output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r        <= {CW{1'b0}};
            row_r        <= {RW{1'b0}};
            valid_out_r  <= 1'b0;
            out_r        <= {DATA_W{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            valid_out_r  <= 1'b0;
            frame_done_r <= 1'b0;
            if (valid_in) begin
                if (last_col_s) begin
                    col_r <= {CW{1'b0}};
                    row_r <= last_row_s ? {RW{1'b0}} : row_r + RW'(1);
                end else begin
                    col_r <= col_r + CW'(1);
                end
                // Bottom-right pixel of a window completes it
                if (col_r[0] && row_r[0]) begin
                    out_r        <= window_max_s;
                    valid_out_r  <= 1'b1;
                    frame_done_r <= last_col_s && last_row_s;
                end
            end
        end
    end

    // Data storage: always written before it is read, so it carries no reset
    always_ff @(posedge clk) begin
        if (valid_in && !col_r[0]) begin
            hold_r <= in;
        end
        if (valid_in && col_r[0] && !row_r[0]) begin
            line_buf_r[buf_idx_s] <= pair_max_s;
        end
    end

    assign valid_out  = valid_out_r;
    assign out        = out_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_maxpool2x2.sv
// Directed bench for maxpool2x2 on a 4x4 frame with hand-computed expected outputs.
module tb_maxpool2x2;

    localparam int DATA_W = 24;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     valid_in = 1'b0;
    logic signed [DATA_W-1:0] din = '0;
    logic                     valid_out;
    logic signed [DATA_W-1:0] dout;
    logic                     frame_done;

    int errors = 0;
    int checks = 0;
    int exp_out = 0;

    maxpool2x2 #(.DATA_W(DATA_W), .IMG_W(4), .IMG_H(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .in         (din),
        .valid_out  (valid_out),
        .out        (dout),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One input cycle, then check all outputs 1 time unit after the edge
    task automatic step(input logic v, input int d, input logic evo, input int eout,
                        input logic efd, input string tag);
        @(negedge clk);
        valid_in = v;
        din      = DATA_W'(d);
        @(posedge clk);
        #1;
        if (evo) exp_out = eout;
        chk({tag, ".valid_out"}, valid_out, evo);
        chk({tag, ".out"}, dout, exp_out);
        chk({tag, ".frame_done"}, frame_done, efd);
    endtask

    // Ramp frame base..base+15: each window's max is its bottom-right pixel
    task automatic run_frame(input int base, input logic gaps, input string tag);
        for (int p = 0; p < 16; p++) begin
            step(1'b1, base + p, (p == 5 || p == 7 || p == 13 || p == 15), base + p,
                 (p == 15), tag);
            if (gaps) step(1'b0, 999, 1'b0, 0, 1'b0, {tag, ".gap"});
        end
    endtask

    int win_px  [16] = '{-8, -3, 0, 0, -6, -1, 0, 0, 0, 0, 7, 7, 0, 0, 7, 7};
    int win_exp [16] = '{0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7};

    initial begin
        // Reset state
        valid_in = 1'b1;
        din      = 24'sd33;
        @(posedge clk);
        #1;
        chk("reset.valid_out", valid_out, 1'b0);
        chk("reset.out", dout, 0);
        chk("reset.frame_done", frame_done, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b1;

        run_frame(0, 1'b0, "cont");
        run_frame(0, 1'b1, "gapped");

        for (int p = 0; p < 16; p++) begin
            step(1'b1, win_px[p], (p == 5 || p == 7 || p == 13 || p == 15), win_exp[p],
                 (p == 15), "window");
        end

        // Partial frame, then asynchronous reset while valid_in is held high
        for (int p = 0; p < 6; p++) begin
            step(1'b1, 50 + p, (p == 5), 55, 1'b0, "prereset");
        end
        @(negedge clk);
        valid_in = 1'b1;
        din      = 24'sd77;
        rst_n    = 1'b0;
        #1;
        exp_out = 0;
        chk("inreset.valid_out", valid_out, 1'b0);
        chk("inreset.out", dout, 0);
        chk("inreset.frame_done", frame_done, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("inreset.valid_out", valid_out, 1'b0);
            chk("inreset.out", dout, 0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        step(1'b0, 0, 1'b0, 0, 1'b0, "postreset");
        run_frame(0, 1'b0, "afterreset");

        run_frame(0, 1'b0, "b2b0");
        run_frame(100, 1'b0, "b2b1");
        step(1'b0, 0, 1'b0, 0, 1'b0, "idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maxpool2x2.md
MAXPOOL2X2 -- requirements
Module: maxpool2x2

Interface
REQ-001 SHALL have parameter DATA_W, default 24, sample width (signed two's complement).
REQ-002 SHALL have parameter IMG_W, default 24, input feature-map width in pixels (even, >=2).
REQ-003 SHALL have parameter IMG_H, default 24, input feature-map height in rows (even, >=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port valid_in  input  1  qualifies in for one pixel this cycle.
REQ-007 SHALL have port in  input  DATA_W signed  activation sample (relu stage output), raster order.
REQ-008 SHALL have port valid_out  output  1  qualifies out for one pooled pixel this cycle.
REQ-009 SHALL have port out  output  DATA_W signed  pooled sample.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse on the last pooled pixel of a frame.

Function
REQ-011 SHALL do 2x2 max pooling, stride 2, on a stream of IMG_W x IMG_H pixels arriving row-major, one pixel per valid_in cycle.
REQ-012 SHALL track position with col counter (0..IMG_W-1) and row counter (0..IMG_H-1), advanced only on valid_in=1; col wraps to 0 and row increments at col=IMG_W-1; row wraps to 0 at frame end (col=IMG_W-1, row=IMG_H-1).
REQ-013 SHALL tolerate arbitrary gaps (valid_in=0): all counters and registers hold; no output generated.
REQ-014 SHALL on even col latch in into a horizontal hold register.
REQ-015 SHALL on odd col form pair_max = signed max(hold register, in).
REQ-016 SHALL on odd col of even row write pair_max to line buffer entry col>>1 (IMG_W/2 entries of DATA_W); no output.
REQ-017 SHALL on odd col of odd row register out = signed max(line buffer[col>>1], pair_max) and assert valid_out for exactly the following cycle.
REQ-018 SHALL have latency exactly 1 cycle: valid_out/out appear on the clock edge sampling the pixel at (odd row, odd col).
REQ-019 SHALL deassert valid_out in every cycle not covered by REQ-017; out holds its last value while valid_out=0.
REQ-020 SHALL use signed comparison; equal operands yield that value.
REQ-021 SHALL pass values unmodified in width (no saturation, no rounding).
REQ-022 SHALL assert frame_done in the same cycle as valid_out for pixel (IMG_H-1, IMG_W-1); low otherwise.
REQ-023 SHALL produce exactly (IMG_W/2)*(IMG_H/2) outputs per frame; back-to-back frames need no idle cycle.
REQ-024 SHALL not reset the line buffer or hold register; their contents are always overwritten before read.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear valid_out=0, out=0, frame_done=0, col=0, row=0.
REQ-026 SHALL, after reset mid-frame, treat the next valid_in pixel as (0,0) of a new frame; no stale partial window contributes to output.
REQ-027 SHALL ignore valid_in while rst_n=0.

Verification (IMG_W=4, IMG_H=4, DATA_W=24)
REQ-028 SHALL pass: frame 0..15 continuous valid_in -> valid_out 4 times, out=5,7,13,15, each 1 cycle after pixels 5,7,13,15; frame_done with 15 only.
REQ-029 SHALL pass: same frame, valid_in toggling 1/0 each cycle -> identical out sequence, valid_out single-cycle pulses, counters hold in gaps.
REQ-030 SHALL pass: window {-8,-3 / -6,-1} in top-left, rest 0 -> first out=-1; window all 7 -> out=7.
REQ-031 SHALL pass: 6 pixels then rst_n low 2 cycles mid-stream, then full frame 0..15 -> exactly 4 outputs 5,7,13,15, valid_out=0 and out=0 during/after reset until first new output.
REQ-032 SHALL pass: two consecutive frames (0..15 then 100..115) with no gap -> outputs 5,7,13,15,105,107,113,115; frame_done twice, at 15 and 115.
